// File: rtl/fetch_stage_if.sv
// Instruction-memory read port between the fetch stage (master) and the memory (slave).
interface fetch_stage_if;
    logic        o_imem_req;
    logic [7:0]  o_imem_addr;
    logic        i_imem_ack;
    logic [15:0] i_imem_rdata;

    modport master (output o_imem_req, o_imem_addr, input i_imem_ack, i_imem_rdata);
    modport slave  (input o_imem_req, o_imem_addr, output i_imem_ack, i_imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, imem request handshake, IF/ID register with a
// one-entry skid buffer for stalls and deferred redirect for in-flight branches.
module fetch_stage #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_run,
    input  logic               i_stall,
    input  logic               i_branch,
    input  logic [7:0]         i_branch_target,
    fetch_stage_if.master      imem,
    output logic [15:0]        o_instr,
    output logic [3:0]         o_opcode,
    output logic [7:0]         o_pc,
    output logic               o_valid
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [7:0]  opc_q, opc_d;
    logic        valid_q, valid_d;
    logic [15:0] skid_instr_q, skid_instr_d;
    logic [7:0]  skid_pc_q, skid_pc_d;
    logic        skid_vld_q, skid_vld_d;
    logic        redir_vld_q, redir_vld_d;
    logic [7:0]  redir_pc_q, redir_pc_d;
    logic [7:0]  pc_inc;
    logic        ack;

    assign pc_inc = pc_q + 8'd1;
    assign ack    = imem.i_imem_ack;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        opc_d        = opc_q;
        valid_d      = valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_vld_d   = skid_vld_q;
        redir_vld_d  = redir_vld_q;
        redir_pc_d   = redir_pc_q;
        case (state_q)
            IDLE: begin
                if (i_branch) begin
                    pc_d       = i_branch_target;
                    valid_d    = 1'b0;
                    skid_vld_d = 1'b0;
                end
                if (i_run) state_d = FETCH;
            end
            FETCH: begin
                if (i_branch) begin
                    valid_d    = 1'b0;
                    skid_vld_d = 1'b0;
                    if (ack) begin
                        pc_d        = i_branch_target;
                        redir_vld_d = 1'b0;
                    end else begin
                        // address must stay stable until ack; redirect after it
                        redir_vld_d = 1'b1;
                        redir_pc_d  = i_branch_target;
                    end
                end else if (ack) begin
                    if (redir_vld_q) begin
                        pc_d        = redir_pc_q;
                        redir_vld_d = 1'b0;
                        if (!i_stall) valid_d = 1'b0;
                    end else if (i_stall) begin
                        skid_instr_d = imem.i_imem_rdata;
                        skid_pc_d    = pc_q;
                        skid_vld_d   = 1'b1;
                        pc_d         = pc_inc;
                        state_d      = HOLD;
                    end else begin
                        instr_d = imem.i_imem_rdata;
                        opc_d   = pc_q;
                        valid_d = 1'b1;
                        pc_d    = pc_inc;
                    end
                end else if (!i_stall) begin
                    valid_d = 1'b0;
                end
            end
            HOLD: begin
                if (i_branch) begin
                    valid_d    = 1'b0;
                    skid_vld_d = 1'b0;
                    pc_d       = i_branch_target;
                    state_d    = FETCH;
                end else if (!i_stall) begin
                    instr_d    = skid_instr_q;
                    opc_d      = skid_pc_q;
                    valid_d    = skid_vld_q;
                    skid_vld_d = 1'b0;
                    state_d    = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            instr_q      <= 16'h0000;
            opc_q        <= 8'h00;
            valid_q      <= 1'b0;
            skid_instr_q <= 16'h0000;
            skid_pc_q    <= 8'h00;
            skid_vld_q   <= 1'b0;
            redir_vld_q  <= 1'b0;
            redir_pc_q   <= 8'h00;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            opc_q        <= opc_d;
            valid_q      <= valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_vld_q   <= skid_vld_d;
            redir_vld_q  <= redir_vld_d;
            redir_pc_q   <= redir_pc_d;
        end
    end

    assign imem.o_imem_req  = (state_q == FETCH);
    assign imem.o_imem_addr = pc_q;
    assign o_instr          = instr_q;
    assign o_opcode         = instr_q[15:12];
    assign o_pc             = opc_q;
    assign o_valid          = valid_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory returns 16'h2100+addr; a scoreboard
// tracks accepted fetches and checks each fresh IF/ID output in order.
module tb_fetch_stage;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       i_run = 1'b0, i_stall = 1'b0, i_branch = 1'b0;
    logic [7:0] i_branch_target = 8'h00;
    logic       ack_drv = 1'b0;
    logic [15:0] o_instr;
    logic [3:0]  o_opcode;
    logic [7:0]  o_pc;
    logic        o_valid;

    int checks = 0;
    int errors = 0;

    fetch_stage_if bus ();
    assign bus.i_imem_ack   = ack_drv;
    assign bus.i_imem_rdata = 16'h2100 + {8'h00, bus.o_imem_addr};

    fetch_stage #(.RESET_PC(8'h00)) dut (
        .clk(clk), .reset_n(reset_n), .i_run(i_run), .i_stall(i_stall),
        .i_branch(i_branch), .i_branch_target(i_branch_target), .imem(bus),
        .o_instr(o_instr), .o_opcode(o_opcode), .o_pc(o_pc), .o_valid(o_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: entries are {pc, instr} of fetches the pipeline should deliver.
    logic [23:0] sb_q[$];
    logic        discard_next = 1'b0;
    logic        last_stall = 1'b1;
    logic        last_rst_n = 1'b0;

    always @(posedge clk) begin
        if (!reset_n) begin
            sb_q.delete();
            discard_next = 1'b0;
        end else if (i_branch) begin
            sb_q.delete();
            discard_next = bus.o_imem_req && !bus.i_imem_ack;
        end else if (bus.o_imem_req && bus.i_imem_ack) begin
            if (discard_next) discard_next = 1'b0;
            else sb_q.push_back({bus.o_imem_addr, bus.i_imem_rdata});
        end
        last_stall = i_stall;
        last_rst_n = reset_n;
    end

    always @(negedge clk) begin
        if (last_rst_n && !last_stall && o_valid === 1'b1) begin
            chk("sb_nonempty", {31'd0, sb_q.size() != 0}, 32'd1);
            if (sb_q.size() != 0) begin
                logic [23:0] e;
                e = sb_q.pop_front();
                chk("sb_pc_instr", {8'h00, o_pc, o_instr}, {8'h00, e});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset
        reset_n = 1'b0;
        tick(); tick();
        chk("rst_req", bus.o_imem_req, 0);
        chk("rst_addr", bus.o_imem_addr, 8'h00);
        chk("rst_instr", o_instr, 16'h0000);
        chk("rst_opcode", o_opcode, 4'h0);
        chk("rst_pc", o_pc, 8'h00);
        chk("rst_valid", o_valid, 0);

        // zero-wait streaming
        reset_n = 1'b1; i_run = 1'b1; ack_drv = 1'b1;
        tick();
        chk("run_req", bus.o_imem_req, 1);
        chk("run_addr", bus.o_imem_addr, 8'h00);
        chk("run_valid0", o_valid, 0);
        tick();
        i_run = 1'b0;
        chk("stream_valid", o_valid, 1);
        chk("stream_pc0", o_pc, 8'h00);
        chk("stream_opcode", o_opcode, 4'h2);
        tick();
        chk("stream_pc1", o_pc, 8'h01);
        tick();
        chk("stream_pc2", o_pc, 8'h02);
        tick(); tick();
        chk("pre_wait_addr", bus.o_imem_addr, 8'h05);

        // ack delayed three cycles on 05
        ack_drv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("wait_addr", bus.o_imem_addr, 8'h05);
            chk("wait_req", bus.o_imem_req, 1);
            tick();
            chk("wait_bubble", o_valid, 0);
        end
        chk("wait_addr4", bus.o_imem_addr, 8'h05);
        ack_drv = 1'b1;
        tick();
        chk("wait_instr", o_instr, 16'h2105);
        chk("wait_pc", o_pc, 8'h05);
        chk("wait_valid", o_valid, 1);

        // two-cycle stall with zero-wait ack
        i_stall = 1'b1;
        tick();
        chk("stall_pc_frozen", o_pc, 8'h05);
        chk("stall_req_drop", bus.o_imem_req, 0);
        tick();
        chk("stall_instr_frozen", o_instr, 16'h2105);
        chk("stall_req_low", bus.o_imem_req, 0);
        i_stall = 1'b0;
        tick();
        chk("release_pc", o_pc, 8'h06);
        chk("release_valid", o_valid, 1);
        chk("release_addr", bus.o_imem_addr, 8'h07);
        tick();
        chk("release_pc_next", o_pc, 8'h07);

        // branch during stalled HOLD
        i_stall = 1'b1;
        tick();
        chk("hold_req", bus.o_imem_req, 0);
        i_branch = 1'b1; i_branch_target = 8'h40;
        tick();
        chk("br_hold_valid", o_valid, 0);
        chk("br_hold_addr", bus.o_imem_addr, 8'h40);
        chk("br_hold_req", bus.o_imem_req, 1);
        i_branch = 1'b0; i_stall = 1'b0;
        tick();
        chk("br_hold_pc", o_pc, 8'h40);
        chk("br_hold_valid1", o_valid, 1);

        // branch while ack outstanding on 07
        i_branch = 1'b1; i_branch_target = 8'h07;
        tick();
        chk("br_to7_addr", bus.o_imem_addr, 8'h07);
        chk("br_to7_valid", o_valid, 0);
        ack_drv = 1'b0; i_branch_target = 8'h10;
        tick();
        chk("pend_addr_a", bus.o_imem_addr, 8'h07);
        chk("pend_valid_a", o_valid, 0);
        i_branch = 1'b0;
        tick();
        chk("pend_addr_b", bus.o_imem_addr, 8'h07);
        ack_drv = 1'b1;
        tick();
        chk("pend_discard", o_valid, 0);
        chk("pend_redirect", bus.o_imem_addr, 8'h10);
        tick();
        chk("pend_pc", o_pc, 8'h10);
        chk("pend_instr", o_instr, 16'h2110);

        // second branch overwrites the pending target
        ack_drv = 1'b0; i_branch = 1'b1; i_branch_target = 8'h30;
        tick();
        i_branch_target = 8'h33;
        tick();
        i_branch = 1'b0; ack_drv = 1'b1;
        tick();
        chk("ovw_addr", bus.o_imem_addr, 8'h33);
        chk("ovw_valid", o_valid, 0);
        tick();
        chk("ovw_pc", o_pc, 8'h33);

        // PC wrap and reset mid-wait
        i_branch = 1'b1; i_branch_target = 8'hFF;
        tick();
        chk("wrap_addr_ff", bus.o_imem_addr, 8'hFF);
        i_branch = 1'b0;
        tick();
        chk("wrap_pc", o_pc, 8'hFF);
        chk("wrap_addr_00", bus.o_imem_addr, 8'h00);
        ack_drv = 1'b0;
        tick();
        reset_n = 1'b0;
        tick();
        chk("mrst_req", bus.o_imem_req, 0);
        chk("mrst_addr", bus.o_imem_addr, 8'h00);
        chk("mrst_instr", o_instr, 16'h0000);
        chk("mrst_opcode", o_opcode, 4'h0);
        chk("mrst_pc", o_pc, 8'h00);
        chk("mrst_valid", o_valid, 0);
        reset_n = 1'b1; ack_drv = 1'b1;
        tick(); tick();
        chk("late_ack_req", bus.o_imem_req, 0);
        chk("late_ack_valid", o_valid, 0);
        chk("late_ack_instr", o_instr, 16'h0000);
        chk("sb_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
